exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
Exception/interrupt initiator for the 5-stage MIPS core. It inspects the instruction committing in MEM and arbitrates its exception flags, ERET and pending interrupts. It drives the one-cycle exception pulses into the CP0 register block, flushes the pipeline, and then issues a redirect PC to fetch through a valid/ready handshake. It sits between the MEM stage, CP0 and the IF PC mux.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception handler entry PC
FLUSH_CYCLES, 2, cycles flush_o is held after commit; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid_i  in  1  valid instruction in MEM this cycle
mem_pc_i  in  32  PC of MEM instruction
mem_delayslot_i  in  1  MEM instruction is in a delay slot
mem_addr_i  in  32  data address or result of MEM instruction
exc_syscall_i / exc_break_i / exc_overflow_i / exc_adel_i / exc_ades_i  in  1 each  synchronous exception flags from MEM
eret_i  in  1  MEM instruction is ERET
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause
epc_i  in  32  CP0 EPC
syscall_flag_o / break_flag_o / overflow_flag_o / address_read_error_flag_o / address_write_error_flag_o / eret_flag_o / int_flag_o  out  1 each  one-cycle pulses to CP0
delayslot_flag_o  out  1  delay-slot bit accompanying the pulse
current_pc_addr_o  out  32  PC accompanying the pulse
badaddr_o  out  32  address accompanying the pulse
flush_o  out  1  flush IF..MEM
redirect_valid_o  out  1  redirect PC valid
redirect_ready_i  in  1  fetch accepts redirect
redirect_pc_o  out  32  new fetch PC
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset:
  - Synchronous, active-high, one clock.
  - rst wins over everything, including mid-sequence.
  - Next state is IDLE and every output is 0, including redirect_pc_o and the captured fields.
- Interrupt pending: int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Trigger: taken in IDLE only, when mem_valid_i=1 and any of the following is true: int_pend, any exc flag, or eret_i.
- Priority, exactly one selected:
  - int > adel > overflow > syscall > break > ades > eret.
  - ERET is ignored whenever any exception or interrupt is also present.
- Capture at the trigger edge: cause code, mem_pc_i, mem_delayslot_i, mem_addr_i.
- FSM states and transitions:
  - IDLE → COMMIT on trigger.
  - COMMIT (exactly 1 cycle):
    - The selected *_flag_o is 1, together with delayslot_flag_o, current_pc_addr_o and badaddr_o from the capture.
    - flush_o=1.
    - Next state is FLUSH.
  - FLUSH:
    - flush_o=1; a 4-bit counter counts FLUSH_CYCLES cycles.
    - On the last cycle, redirect_pc_o is registered: EXC_VECTOR for exception or interrupt, epc_i for ERET. CP0 EPC has already been updated at the end of COMMIT, so epc_i is stable here.
    - Next state is REDIRECT.
  - REDIRECT:
    - redirect_valid_o=1, flush_o=1, redirect_pc_o held stable.
    - Stays in REDIRECT until redirect_ready_i=1.
    - On the accepting edge, returns to IDLE; valid and flush drop in the following cycle.
- Pulse rules:
  - All *_flag_o outputs are 0 outside COMMIT.
  - The companion fields are 0 outside COMMIT.
- Latency:
  - Trigger at cycle T gives the pulse at T+1 and redirect_valid_o at T+2+FLUSH_CYCLES.
  - Minimum total occupancy is 2+FLUSH_CYCLES cycles.
- busy_o=1 in every state except IDLE.
- mem_valid_i, the exception flags and eret_i are ignored while busy. The flushed instructions must not retrigger.
- A trigger is allowed in the IDLE cycle immediately after a REDIRECT acceptance.
- Flags with mem_valid_i=0 are ignored.
- int_pend with mem_valid_i=0 waits; it is never taken without a PC.
- No wrap-around issue: the counter saturates at FLUSH_CYCLES-1 and reloads on FLUSH entry.

Test Plan:
- syscall, mem_pc_i=32'h00400020, no delay slot → at T+1: syscall_flag_o=1, current_pc_addr_o=32'h00400020, delayslot_flag_o=0, flush_o=1 → redirect_valid_o at T+4 (FLUSH_CYCLES=2) with redirect_pc_o=32'hBFC00380; ready held 0 for 3 cycles keeps valid and PC stable.
- adel and overflow together, mem_addr_i=32'h00000003, mem_delayslot_i=1 → only address_read_error_flag_o pulses, badaddr_o=3, delayslot_flag_o=1; overflow_flag_o stays 0.
- eret with CP0 model epc=32'h00400100 → eret_flag_o at T+1, redirect_pc_o=32'h00400100.
- status_i=32'h0000FF01, cause_i[10]=1, mem_valid_i=0 for 3 cycles then 1, plus break → no action until valid; then int_flag_o=1 and break_flag_o=0; status_i[1]=1 instead → no interrupt, break_flag_o=1.
- A second syscall presented every cycle while busy → exactly one pulse per sequence; the next sequence starts the cycle after the REDIRECT handshake.
- rst asserted during FLUSH and during REDIRECT → next cycle all outputs 0 and busy_o=0; no redirect is issued.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt initiator: arbitrates MEM-stage exceptions, ERET and interrupts,
// pulses CP0 for one cycle, flushes the pipeline, then hands a redirect PC to fetch.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        exc_syscall_i,
    input  logic        exc_break_i,
    input  logic        exc_overflow_i,
    input  logic        exc_adel_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        syscall_flag_o,
    output logic        break_flag_o,
    output logic        overflow_flag_o,
    output logic        address_read_error_flag_o,
    output logic        address_write_error_flag_o,
    output logic        eret_flag_o,
    output logic        int_flag_o,
    output logic        delayslot_flag_o,
    output logic [31:0] current_pc_addr_o,
    output logic [31:0] badaddr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    input  logic        redirect_ready_i,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;
    localparam logic [3:0] LAST_CNT   = 4'(FLUSH_CYCLES - 1);

    // One-hot selection, bit order {int, adel, ovf, syscall, break, ades, eret}
    logic [1:0]  state_q, state_d;
    logic [6:0]  sel_q, sel_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        int_pend;
    logic [6:0]  sel_now;
    logic        in_commit;

    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        sel_now = '0;
        if (int_pend)            sel_now[6] = 1'b1;
        else if (exc_adel_i)     sel_now[5] = 1'b1;
        else if (exc_overflow_i) sel_now[4] = 1'b1;
        else if (exc_syscall_i)  sel_now[3] = 1'b1;
        else if (exc_break_i)    sel_now[2] = 1'b1;
        else if (exc_ades_i)     sel_now[1] = 1'b1;
        else if (eret_i)         sel_now[0] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pc_d          = pc_q;
        ds_d          = ds_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid_i && (|sel_now)) begin
                    state_d = S_COMMIT;
                    sel_d   = sel_now;
                    pc_d    = mem_pc_i;
                    ds_d    = mem_delayslot_i;
                    addr_d  = mem_addr_i;
                end
            end
            S_COMMIT: begin
                state_d = S_FLUSH;
                cnt_d   = 4'd0;
            end
            S_FLUSH: begin
                // EPC was written by CP0 at the end of COMMIT, so epc_i is valid here
                if (cnt_q == LAST_CNT) begin
                    state_d       = S_REDIRECT;
                    redirect_pc_d = sel_q[0] ? epc_i : EXC_VECTOR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (redirect_ready_i) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            pc_q          <= '0;
            ds_q          <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pc_q          <= pc_d;
            ds_q          <= ds_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign in_commit = (state_q == S_COMMIT);

    assign int_flag_o                 = in_commit & sel_q[6];
    assign address_read_error_flag_o  = in_commit & sel_q[5];
    assign overflow_flag_o            = in_commit & sel_q[4];
    assign syscall_flag_o             = in_commit & sel_q[3];
    assign break_flag_o               = in_commit & sel_q[2];
    assign address_write_error_flag_o = in_commit & sel_q[1];
    assign eret_flag_o                = in_commit & sel_q[0];
    assign delayslot_flag_o           = in_commit & ds_q;
    assign current_pc_addr_o          = in_commit ? pc_q : 32'd0;
    assign badaddr_o                  = in_commit ? addr_q : 32'd0;

    assign flush_o          = (state_q != S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign redirect_valid_o = (state_q == S_REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;

endmodule
